// File: rtl/if_pkg.sv
// Shared payload types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int unsigned PC_W = 32;
  localparam int unsigned IW   = 32;

  localparam logic [IW-1:0] INST_NOP = 32'h0340_0000;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [IW-1:0]   inst;
    logic            adef;
  } ifetch_entry_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            stale;
  } inflight_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and a per-entry mark bit (1 = empty or stale slot).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   flush_mark,
  output logic [WIDTH-1:0]       head_data,
  output logic                   head_mark,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] live_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] mark, mark_next;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (count != '0) && !flush;
  assign head_data = mem[rd_ptr];
  assign head_mark = mark[rd_ptr];
  assign live_cnt  = CNT_W'($countones(~mark));

  // Entries present before this cycle get marked; a same-cycle push stays live.
  always_comb begin
    mark_next = mark;
    if (flush || flush_mark) mark_next = '1;
    if (do_pop)              mark_next[rd_ptr] = 1'b1;
    if (push)                mark_next[wr_ptr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      mark   <= '1;
    end else begin
      mark <= mark_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= push ? CNT_W'(1) : '0;
      end else begin
        if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch front end: multiple outstanding inst_sram fetches feeding a
// decoupling instruction buffer, with stale-marking on redirect.
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       INST_W          = 32,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter int unsigned       BUF_DEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(32'h1c00_0000)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              redirect_valid,
  input  logic [ADDR_W-1:0]                 redirect_pc,
  input  logic                              fetch_stall,
  output logic                              inst_sram_req,
  output logic                              inst_sram_wr,
  output logic [1:0]                        inst_sram_size,
  output logic [3:0]                        inst_sram_wstrb,
  output logic [ADDR_W-1:0]                 inst_sram_addr,
  output logic [INST_W-1:0]                 inst_sram_wdata,
  input  logic                              inst_sram_addr_ok,
  input  logic                              inst_sram_data_ok,
  input  logic [INST_W-1:0]                 inst_sram_rdata,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ADDR_W-1:0]                 out_pc,
  output logic [INST_W-1:0]                 out_inst,
  output logic                              out_adef,
  output logic [$clog2(MAX_OUTSTANDING):0]  inflight_cnt
);

  localparam int unsigned IF_CW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned BUF_CW = $clog2(BUF_DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic              adef_hold, hold_eff, aligned, credit_ok, buf_space;
  logic              accept, if_pop, head_stale, live_push, adef_push, buf_push, buf_pop;
  logic [IF_CW-1:0]  if_cnt, if_live, live_eff;
  logic [BUF_CW-1:0] buf_cnt, buf_live, buf_eff;
  logic              if_head_mark, buf_head_mark;
  inflight_t         if_push_data, if_head;
  ifetch_entry_t     buf_push_data, buf_head;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = '0;

  // A redirect retires every older in-flight entry and empties the buffer,
  // so credit and hold are evaluated as if that had already happened.
  assign req_pc    = redirect_valid ? redirect_pc : fetch_pc;
  assign hold_eff  = adef_hold && !redirect_valid;
  assign live_eff  = redirect_valid ? '0 : if_live;
  assign buf_eff   = redirect_valid ? '0 : buf_live;
  assign aligned   = (req_pc[1:0] == 2'b00);
  assign credit_ok = (32'(live_eff) + 32'(buf_eff)) < BUF_DEPTH;
  assign buf_space = redirect_valid || (32'(buf_cnt) < BUF_DEPTH);

  assign inst_sram_addr = req_pc;
  assign inst_sram_req  = !reset && !fetch_stall && !hold_eff && aligned &&
                          (32'(if_cnt) < MAX_OUTSTANDING) && credit_ok;
  assign accept         = inst_sram_req && inst_sram_addr_ok;

  assign if_pop     = !reset && inst_sram_data_ok && (if_cnt != '0);
  assign head_stale = if_head.stale || if_head_mark || redirect_valid;
  assign live_push  = if_pop && !head_stale;
  assign adef_push  = !reset && !fetch_stall && !hold_eff && !aligned &&
                      (live_eff == '0) && buf_space;
  assign buf_push   = live_push || adef_push;
  assign buf_pop    = out_valid && out_ready;

  always_comb begin
    if_push_data       = '0;
    if_push_data.pc    = PC_W'(req_pc);
    buf_push_data      = '0;
    if (adef_push) begin
      buf_push_data.pc   = PC_W'(req_pc);
      buf_push_data.adef = 1'b1;
    end else begin
      buf_push_data.pc   = if_head.pc;
      buf_push_data.inst = IW'(inst_sram_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      adef_hold <= 1'b0;
    end else begin
      if (accept)              fetch_pc <= req_pc + ADDR_W'(4);
      else if (redirect_valid) fetch_pc <= redirect_pc;
      if (adef_push)           adef_hold <= 1'b1;
      else if (redirect_valid) adef_hold <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH($bits(inflight_t)), .DEPTH(MAX_OUTSTANDING)) u_inflight (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_data  (if_push_data),
    .pop        (if_pop),
    .flush      (1'b0),
    .flush_mark (redirect_valid),
    .head_data  (if_head),
    .head_mark  (if_head_mark),
    .count      (if_cnt),
    .live_cnt   (if_live)
  );

  sync_fifo #(.WIDTH($bits(ifetch_entry_t)), .DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (buf_push),
    .push_data  (buf_push_data),
    .pop        (buf_pop),
    .flush      (redirect_valid),
    .flush_mark (1'b0),
    .head_data  (buf_head),
    .head_mark  (buf_head_mark),
    .count      (buf_cnt),
    .live_cnt   (buf_live)
  );

  // A clear mark on the head slot means it holds a real entry.
  assign out_valid    = !reset && !buf_head_mark;
  assign out_pc       = ADDR_W'(buf_head.pc);
  assign out_inst     = out_valid ? INST_W'(buf_head.inst) : INST_W'(INST_NOP);
  assign out_adef     = out_valid && buf_head.adef;
  assign inflight_cnt = if_cnt;

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
Parametrised instruction-fetch front end that replaces the single-request fetch stage. Keeps up to MAX_OUTSTANDING fetches in flight on the inst_sram request/response bus. Buffers returned instructions in a BUF_DEPTH-entry queue feeding ID through a valid/ready handshake. Handles branch, exception and ertn redirects by marking in-flight responses stale and discarding them, with no extra blocking registers.

Parameters:
ADDR_W, 32, PC/address width
INST_W, 32, instruction width
MAX_OUTSTANDING, 2, max accepted-but-unanswered requests (power of 2, >=1)
BUF_DEPTH, 4, instruction buffer entries (power of 2, >=2)
RESET_PC, 32'h1c000000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  branch, exception or ertn redirect this cycle
redirect_pc  in  ADDR_W  redirect target
fetch_stall  in  1  suppress new requests (axi/div/load-use block)
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  tied 0
inst_sram_size  out  2  tied 2'b10
inst_sram_wstrb  out  4  tied 0
inst_sram_addr  out  ADDR_W  request address
inst_sram_wdata  out  INST_W  tied 0
inst_sram_addr_ok  in  1  request accepted
inst_sram_data_ok  in  1  response valid, in order
inst_sram_rdata  in  INST_W  response data
out_valid  out  1  buffer head valid
out_ready  in  1  ID accepts head
out_pc  out  ADDR_W  head pc
out_inst  out  INST_W  head instruction (0 when adef)
out_adef  out  1  head pc misaligned
inflight_cnt  out  $clog2(MAX_OUTSTANDING)+1  debug count of outstanding requests

Behaviour:
- Reset: fetch_pc<=RESET_PC; in-flight queue, buffer and adef_hold cleared. inst_sram_req=0 and out_valid=0 while reset is high. data_ok arriving with an empty in-flight queue is ignored.
- Request address: req_pc = redirect_valid ? redirect_pc : fetch_pc. This gives a zero-bubble redirect. inst_sram_addr=req_pc.
- inst_sram_req = !reset & !fetch_stall & !adef_hold & req_pc[1:0]==0 & inflight_cnt<MAX_OUTSTANDING & (live_cnt+buf_cnt)<BUF_DEPTH.
  - live_cnt counts non-stale in-flight entries.
  - The credit rule guarantees no buffer overflow, so data_ok is never refused.
- Accept (req & addr_ok): push {req_pc, stale=0} into the in-flight queue. fetch_pc<=req_pc+4 (wraps modulo 2^ADDR_W).
- Response (data_ok): pop the in-flight head.
  - Stale entry: data dropped.
  - Otherwise: push {pc, rdata, adef=0} into the buffer.
  - out_valid rises the cycle after data_ok; there is no bypass.
- Redirect: every in-flight entry present before this cycle is marked stale, including a head popped this same cycle, whose data is dropped. A request accepted in the redirect cycle uses redirect_pc and is not stale. The buffer is flushed; a simultaneous out pop is void. adef_hold is cleared. Without acceptance, fetch_pc<=redirect_pc.
- Misaligned fetch: if req_pc[1:0]!=0, no bus request is made.
  - Once live_cnt==0, the buffer has space and !fetch_stall: push {req_pc, 0, adef=1} and set adef_hold.
  - adef_hold blocks further fetch until the next redirect.
- Output: out_* reflect the buffer head. A pop on out_valid&out_ready happens in the same cycle as a push; a full buffer with a simultaneous pop and push is legal.
- Simultaneous addr_ok and data_ok on one in-flight slot are legal; inflight_cnt is unchanged.
- Reset mid-operation discards everything. The bus is assumed reset together with the core.

Decomposition:
- Package if_pkg: ifetch_entry_t {pc, inst, adef}; inflight_t {pc, stale}; constant INST_NOP.
- One sub-module, sync_fifo (parametrised width/depth, push/pop/flush/count). It is instantiated twice: in-flight queue and instruction buffer.
- Stale marking is a per-entry bit vector inside the in-flight instance, provided through a flush_mark input on sync_fifo.

Test Plan:
- Reset release, addr_ok=1 always, data_ok 1 cycle later -> addrs 1c000000, 1c000004, 1c000008 in consecutive cycles; out_pc follows in order, with out_inst equal to rdata.
- out_ready=0 for 10 cycles -> at most BUF_DEPTH=4 requests accepted; req drops; no data lost once out_ready=1.
- Two requests in flight (pc 1c000010, 1c000014), redirect to 1c000100 -> both responses dropped; first out_pc=1c000100; addr=1c000100 in the redirect cycle.
- Redirect in the same cycle as data_ok of a live head -> that data dropped, buffer empty the next cycle.
- Redirect to 1c000102 -> no bus request; after drain, out_adef=1, out_pc=1c000102; no further req until redirect to 1c000200.
- fetch_stall=1 with 2 in flight -> no new req; responses still buffered; req resumes the cycle stall drops.
